// File: rtl/stackcalc_pkg.sv
// ============================================================================
// Module : stackcalc_pkg
// Brief  : Shared opcode encoding, sequencer state type and stack sizing for
//          the stack calculator (sequencer, ALU and the attached stack).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package stackcalc_pkg;

   // Default stack capacity in words, shared with the stack itself
   localparam int STACK_SIZE_DEFAULT = 8;

   // Width of a stack word
   localparam int WORD_W = 4;

   // Opcode encoding
   localparam logic [2:0] OP_PUSH = 3'b000;
   localparam logic [2:0] OP_POP  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_DUP  = 3'b111;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_POPA = 2'd1,
      ST_POPB = 2'd2,
      ST_PUSH = 2'd3
   } state_e;

   // True for the two-operand opcodes (consume two words, push one)
   function automatic logic is_binary_op(input logic [2:0] op);
      return (op != OP_PUSH) && (op != OP_POP) && (op != OP_DUP);
   endfunction

endpackage : stackcalc_pkg

`default_nettype wire

// File: rtl/stack_alu.sv
// ============================================================================
// Module : stack_alu
// Brief  : 4-bit combinational operation unit. a is the second stack entry,
//          b the top; all results wrap modulo 16.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stack_alu
   import stackcalc_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic [2:0]        op,
   output logic [WORD_W-1:0] y
);

   // Operation select; carry and borrow fall off the top bit
   always_comb begin
      y = '0;
      case (op)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         default: y = '0;
      endcase
   end

endmodule : stack_alu

`default_nettype wire

// File: rtl/stack_sequencer.sv
// ============================================================================
// Module : stack_sequencer
// Brief  : Accepts calculator operations and drives an external stack with
//          the pop/push sequence each one needs, tracking occupancy and the
//          last result, and rejecting operations that would under/overflow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stack_sequencer
   import stackcalc_pkg::*;
#(
   parameter int STACK_SIZE = STACK_SIZE_DEFAULT
)
(
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                op_valid,
   input  logic [2:0]                          op_code,
   input  logic [WORD_W-1:0]                   op_data,
   output logic                                op_ready,
   output logic                                stk_mode,
   output logic                                stk_move,
   output logic [WORD_W-1:0]                   stk_word,
   input  logic [WORD_W-1:0]                   top_word,
   input  logic [WORD_W-1:0]                   second_word,
   output logic [WORD_W-1:0]                   result,
   output logic [$clog2(STACK_SIZE+1)-1:0]     depth,
   output logic                                err
);

   localparam int                 DEPTH_W    = $clog2(STACK_SIZE + 1);
   localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(STACK_SIZE);
   localparam logic [DEPTH_W-1:0] ONE        = DEPTH_W'(1);
   localparam logic [DEPTH_W-1:0] TWO        = DEPTH_W'(2);

   state_e              state_q, state_d;
   logic [WORD_W-1:0]   work_q, work_d;
   logic [WORD_W-1:0]   result_q, result_d;
   logic [DEPTH_W-1:0]  depth_q, depth_d;
   logic                err_q, err_d;
   // Set for binary ops: POPB continues into PUSH instead of returning to IDLE
   logic                chain_push_q, chain_push_d;

   logic                accept_w;
   logic                reject_w;
   logic [WORD_W-1:0]   alu_y_w;

   stack_alu u_alu (
      .a  (second_word),
      .b  (top_word),
      .op (op_code),
      .y  (alu_y_w)
   );

   assign accept_w = op_valid && (state_q == ST_IDLE);

   // Occupancy check that decides whether an offered op is rejected
   always_comb begin
      reject_w = 1'b0;
      case (op_code)
         OP_PUSH: reject_w = (depth_q == FULL_DEPTH);
         OP_POP:  reject_w = (depth_q == '0);
         OP_DUP:  reject_w = (depth_q == '0) || (depth_q == FULL_DEPTH);
         default: reject_w = (depth_q < TWO);
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state selection for each op's pop/push sequence
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_w && !reject_w) begin
               case (op_code)
                  OP_PUSH, OP_DUP: state_d = ST_PUSH;
                  OP_POP:          state_d = ST_POPB;
                  default:         state_d = ST_POPA;
               endcase
            end
         end
         ST_POPA: state_d = ST_POPB;
         ST_POPB: state_d = chain_push_q ? ST_PUSH : ST_IDLE;
         ST_PUSH: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Stack drive and handshake outputs, decoded from state
   always_comb begin
      op_ready = (state_q == ST_IDLE);
      stk_move = (state_q != ST_IDLE);
      stk_mode = (state_q == ST_PUSH);
      stk_word = (state_q == ST_PUSH) ? work_q : '0;
   end

   // Datapath next values: operands are captured at accept, depth follows moves
   always_comb begin
      work_d       = work_q;
      result_d     = result_q;
      depth_d      = depth_q;
      err_d        = 1'b0;
      chain_push_d = chain_push_q;
      if (accept_w) begin
         if (reject_w) begin
            err_d = 1'b1;
         end else begin
            chain_push_d = is_binary_op(op_code);
            case (op_code)
               OP_PUSH: begin
                  work_d   = op_data;
                  result_d = op_data;
               end
               OP_POP: begin
                  result_d = top_word;
               end
               OP_DUP: begin
                  work_d   = top_word;
                  result_d = top_word;
               end
               default: begin
                  work_d   = alu_y_w;
                  result_d = alu_y_w;
               end
            endcase
         end
      end
      case (state_q)
         ST_POPA, ST_POPB: depth_d = depth_q - ONE;
         ST_PUSH:          depth_d = depth_q + ONE;
         default:          depth_d = depth_q;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work_q       <= '0;
         result_q     <= '0;
         depth_q      <= '0;
         err_q        <= 1'b0;
         chain_push_q <= 1'b0;
      end else begin
         work_q       <= work_d;
         result_q     <= result_d;
         depth_q      <= depth_d;
         err_q        <= err_d;
         chain_push_q <= chain_push_d;
      end
   end

   assign result = result_q;
   assign depth  = depth_q;
   assign err    = err_q;

endmodule : stack_sequencer

`default_nettype wire
